pwm_ramp: RTL

Memory-mapped duty-cycle ramp generator that sits directly upstream of the PWM compare stage. Software programs a target duty, step size and rate over the MIPS peripheral bus; the block then slews its 12-bit `Duty` output toward the target one step per rate tick, so LED brightness fades instead of jumping. `Duty` drives the PWM comparator's 12-bit compare input. An optional breathing mode bounces the duty continuously between 0 and the target.

---
 rtl/pwm_ramp.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_ramp.sv
// pwm_ramp: bus-programmed duty slew generator feeding the 12-bit PWM compare input.
// Define PWM_RAMP_BREATHE_EN to build the continuous 0 <-> TARGET breathing mode.
module pwm_ramp #(
  parameter logic [11:0] BASE = 12'h100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_N,
  input  logic        WR_N,
  input  logic [11:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic [11:0] Duty,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  localparam logic [11:0] ADDR_TARGET = BASE;
  localparam logic [11:0] ADDR_STEP   = BASE + 12'h004;
  localparam logic [11:0] ADDR_RATE   = BASE + 12'h008;
  localparam logic [11:0] ADDR_CTRL   = BASE + 12'h00C;

  state_t             state_reg;
  state_t             state_next;
  logic [11:0]        target_reg;
  logic [7:0]         step_reg;
  logic [15:0]        rate_reg;
  logic               en_reg;
  logic               breathe_on;
  logic [15:0]        presc_reg;
  logic [11:0]        duty_reg;
  logic [11:0]        duty_next;
  logic               done_reg;
  logic               done_next;
  logic               dir_up;
  logic               reached;

  logic               wr_en;
  logic               rd_en;
  logic               wr_target;
  logic               wr_step;
  logic               wr_rate;
  logic               wr_ctrl;
  logic               snap;
  logic               en_rise;
  logic               tick;

  logic [11:0]        eff_target;
  logic [12:0]        up_sum;
  logic signed [12:0] down_diff;
  logic [11:0]        up_val;
  logic [11:0]        down_val;

  logic               unused_data;
  assign unused_data = ^DataIn[31:16];

  // Bus decode
  assign wr_en     = !CS_N && !WR_N;
  assign rd_en     = !CS_N && WR_N;
  assign wr_target = wr_en && (Addr == ADDR_TARGET);
  assign wr_step   = wr_en && (Addr == ADDR_STEP);
  assign wr_rate   = wr_en && (Addr == ADDR_RATE);
  assign wr_ctrl   = wr_en && (Addr == ADDR_CTRL);
  assign snap      = wr_ctrl && DataIn[2];
  assign en_rise   = wr_ctrl && DataIn[0] && !en_reg;

  // Programmable registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_reg <= 12'h000;
      step_reg   <= 8'd1;
      rate_reg   <= 16'h0000;
      en_reg     <= 1'b0;
    end else begin
      if (wr_target) begin
        target_reg <= DataIn[11:0];
      end
      if (wr_step) begin
        step_reg <= (DataIn[7:0] == 8'd0) ? 8'd1 : DataIn[7:0];
      end
      if (wr_rate) begin
        rate_reg <= DataIn[15:0];
      end
      if (wr_ctrl) begin
        en_reg <= DataIn[0];
      end
    end
  end

`ifdef PWM_RAMP_BREATHE_EN
  logic breathe_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      breathe_reg <= 1'b0;
    end else if (wr_ctrl) begin
      breathe_reg <= DataIn[1];
    end
  end

  assign breathe_on = breathe_reg;
`else
  assign breathe_on = 1'b0;
`endif

  // Prescaler is held at 0 while idle so the first step lands RATE+1 edges after entering UP/DOWN
  assign tick = en_reg && (presc_reg == rate_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg <= 16'h0000;
    end else if (wr_rate || en_rise || !en_reg || (state_reg == S_IDLE)) begin
      presc_reg <= 16'h0000;
    end else if (tick) begin
      presc_reg <= 16'h0000;
    end else begin
      presc_reg <= presc_reg + 16'd1;
    end
  end

  // While breathing downward the internal goal is 0 instead of TARGET
  assign eff_target = (breathe_on && (state_reg == S_DOWN)) ? 12'h000 : target_reg;

  // 13-bit step arithmetic clamps at the goal instead of wrapping
  assign up_sum    = {1'b0, duty_reg} + {5'd0, step_reg};
  assign down_diff = $signed({1'b0, duty_reg}) - $signed({5'd0, step_reg});
  assign up_val    = (up_sum > {1'b0, eff_target}) ? eff_target : up_sum[11:0];
  assign down_val  = (down_diff < $signed({1'b0, eff_target})) ? eff_target : down_diff[11:0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next = state_reg;
    duty_next  = duty_reg;
    done_next  = 1'b0;
    reached    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (en_reg && !(breathe_on && (target_reg == 12'h000))) begin
          if (duty_reg < target_reg) begin
            state_next = S_UP;
          end else if (duty_reg > target_reg) begin
            state_next = S_DOWN;
          end
        end
      end
      S_UP, S_DOWN: begin
        if (!en_reg) begin
          state_next = S_IDLE;
        end else begin
          // Direction follows the live comparison, so a retarget turns the ramp around
          if (duty_reg == eff_target) begin
            reached = 1'b1;
          end else if (tick) begin
            duty_next = (duty_reg < eff_target) ? up_val : down_val;
            reached   = (duty_next == eff_target);
            done_next = reached && !breathe_on;
          end
          if (reached) begin
            if (!breathe_on) begin
              state_next = S_IDLE;
            end else if (eff_target == 12'h000) begin
              state_next = (target_reg == 12'h000) ? S_IDLE : S_UP;
            end else begin
              state_next = S_DOWN;
            end
          end else begin
            state_next = (duty_next < eff_target) ? S_UP : S_DOWN;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (snap) begin
      state_next = S_IDLE;
      duty_next  = target_reg;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_reg <= 12'h000;
      done_reg <= 1'b0;
    end else begin
      duty_reg <= duty_next;
      done_reg <= done_next;
    end
  end

  // Outputs
  always_comb begin
    Busy   = (state_reg != S_IDLE);
    dir_up = (state_reg == S_UP);
  end

  assign Duty = duty_reg;
  assign Done = done_reg;

  always_comb begin
    DataOut = 32'h0000_0000;
    if (rd_en) begin
      case (Addr)
        ADDR_TARGET: DataOut = {20'h00000, target_reg};
        ADDR_STEP:   DataOut = {24'h000000, step_reg};
        ADDR_RATE:   DataOut = {16'h0000, rate_reg};
        ADDR_CTRL:   DataOut = {16'h0000, Busy, dir_up, 2'b00, duty_reg};
        default:     DataOut = 32'h0000_0000;
      endcase
    end
  end

endmodule
